stream_prod: RTL
================

# stream_prod

Programmable stream producer: on a start command it emits `len` data words on `data`, one per `val` strobe. The word sequence is `base`, `base+step`, `base+2*step`, … (mod 2^W), with a configurable idle gap between words. It is the transmitting end of the val/data stream that the accumulating consumer sums. It also keeps its own running sum of emitted words, so a bench can compare it directly with the consumer's result.

## Interface
- W, 8, data/sum width
- LEN_W, 8, width of word count `len`
- GAP_W, 4, width of inter-word gap `gap`

One clock; reset is synchronous and active-high.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  command strobe, sampled only in IDLE
- stop  in  1  abort request, sampled in SEND/GAP
- len  in  LEN_W  number of words to emit, latched on accepted start
- base  in  W  first word, latched on accepted start
- step  in  W  increment between words, latched on accepted start
- gap  in  GAP_W  idle cycles between consecutive words, latched on accepted start
- busy  out  1  high in SEND, GAP, DONE
- val  out  1  data valid strobe, one cycle per word
- data  out  W  current word; meaningful only while val=1
- done  out  1  one-cycle pulse after last word (or after len=0 start)
- sum  out  W  mod-2^W sum of words emitted since last accepted start

## Operation
- All outputs are registered. Reset values: busy=0, val=0, data=0, done=0, sum=0. The FSM resets to IDLE and all latched registers are cleared.
- IDLE: busy=0, val=0. On start=1:
  - Latch len, base, step, gap and clear sum.
  - Load the word counter `cnt` with 0 and the current word `cur` with base.
  - len≠0 → SEND; len=0 → DONE.
- SEND (one cycle per word):
  - Outputs: val=1, data=cur; sum updates to sum+cur at the end of the cycle.
  - Update cur←cur+step (wraps mod 2^W) and cnt←cnt+1.
  - If cnt==len−1 → DONE.
  - Else if gap==0 → SEND.
  - Else → GAP with gcnt←gap.
- GAP: val=0, busy=1. gcnt decrements each cycle; when gcnt reaches 1 → SEND.
- DONE: done=1, val=0, busy=1, for exactly one cycle, then → IDLE.
- stop=1 sampled in SEND or GAP:
  - Next state is IDLE; no done pulse.
  - A word whose val is already high in the current cycle counts as emitted and is added to sum.
  - sum holds its value until the next accepted start.
- Simultaneous events and priority:
  - start outside IDLE is ignored, including during the DONE cycle.
  - stop in IDLE or DONE is ignored.
  - rst has priority over start and stop.
  - If stop and the last word coincide, stop wins: no done pulse.
- Arithmetic:
  - All additions truncate to W bits.
  - cnt is LEN_W bits; len up to 2^LEN_W−1 is supported.
  - data holds its last value when val=0.

## Timing
- Start sampled at rising edge k → first val=1 in cycle k+1 (latency 1).
- With latched gap=g, consecutive val pulses are g+1 cycles apart. The last word appears in cycle k+1+(len−1)(g+1).
- done is high in the cycle immediately after the last val cycle. busy falls the cycle after done.
- len=0: done is high in cycle k+1 with no val; busy is high only in that cycle.
- Earliest next accepted start: the edge ending the first IDLE cycle after done.
- sum is valid (final) in the done cycle and holds its value afterwards.
- Reset asserted mid-run: at the next edge all outputs go to reset values and the FSM goes to IDLE; no done pulse.

## Test plan
- Basic run: len=5, base=3, step=2, gap=0, start at edge k → val high cycles k+1..k+5, data 3,5,7,9,11; done at k+6; sum=35; busy low at k+7.
- Wrap-around: len=4, base=250, step=3, gap=0 → data 250,253,0,3; sum=250 (506 mod 256).
- Gap: len=3, base=1, step=1, gap=2 → val at k+1,k+4,k+7 with data 1,2,3; done at k+8; sum=6; val=0 in all other cycles.
- Edge commands:
  - len=0 start → done at k+1, no val, sum=0.
  - start pulsed during SEND and again during the DONE cycle → both ignored, sequence unchanged.
- Abort and reset:
  - stop during the third word of len=6, base=10, step=10 → words 10,20,30 emitted, sum=60, IDLE next cycle, no done.
  - rst mid-run → all outputs 0 next cycle; a new start then runs normally.
- Back-to-back: consumer-style accumulator attached; two runs of (len=4, base=1, step=1) → accumulator total 20, matches 2× producer sum of 10.

Source files
------------

// File: rtl/stream_prod.sv
// stream_prod: programmable val/data word producer with running sum of emitted words
module stream_prod #(
    parameter int W     = 8,
    parameter int LEN_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     base,
    input  logic [W-1:0]     step,
    input  logic [GAP_W-1:0] gap,
    output logic             busy,
    output logic             val,
    output logic [W-1:0]     data,
    output logic             done,
    output logic [W-1:0]     sum
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q, cnt, cnt_n;
    logic [W-1:0]     step_q, cur, cur_n, sum_n;
    logic [GAP_W-1:0] gap_q, gcnt, gcnt_n;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and next datapath values; cur is the word emitted in the next SEND
    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        sum_n   = sum;
        case (state)
            IDLE: if (start) begin
                cur_n   = base;
                cnt_n   = '0;
                sum_n   = '0;
                state_n = (len == '0) ? DONE : SEND;
            end
            SEND: begin
                sum_n = sum + cur;
                cur_n = cur + step_q;
                cnt_n = cnt + LEN_W'(1);
                if (stop)                          state_n = IDLE;
                else if (cnt == len_q - LEN_W'(1)) state_n = DONE;
                else if (gap_q == '0)              state_n = SEND;
                else begin
                    state_n = GAP;
                    gcnt_n  = gap_q;
                end
            end
            GAP: begin
                gcnt_n = gcnt - GAP_W'(1);
                if (stop)                     state_n = IDLE;
                else if (gcnt == GAP_W'(1))   state_n = SEND;
            end
            default: state_n = IDLE;
        endcase
    end

    // latched command, counters and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            step_q <= '0;
            gap_q  <= '0;
            cur    <= '0;
            cnt    <= '0;
            gcnt   <= '0;
            busy   <= 1'b0;
            val    <= 1'b0;
            data   <= '0;
            done   <= 1'b0;
            sum    <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q  <= len;
                step_q <= step;
                gap_q  <= gap;
            end
            cur  <= cur_n;
            cnt  <= cnt_n;
            gcnt <= gcnt_n;
            sum  <= sum_n;
            busy <= state_n != IDLE;
            val  <= state_n == SEND;
            done <= state_n == DONE;
            if (state_n == SEND) data <= cur_n;
        end
    end
endmodule
